noise_detector_stream: RTL

- Streaming, pipelined successor to the combinational salt/pepper detector.
- Accepts one N-pixel window per handshake and flags each pixel as salt, pepper or clean against a programmable tolerance band.
- Passes the window downstream with its flags, and accumulates a per-frame count of noisy centre pixels.
- Sits between the window generator and the switching median filter stage.

---
 rtl/noise_detector_stream_pkg.sv | 24 ++
 rtl/noise_detector_stream_if.sv | 28 ++
 rtl/noise_detector_stream_classify.sv | 17 +
 rtl/noise_detector_stream.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/noise_detector_stream_pkg.sv
// Shared defaults and helper functions for the streaming salt/pepper detector.
package noise_det_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned WIN_DEF   = 9;
  localparam int unsigned CNT_W_DEF = 16;

  // Largest pixel value for a given pixel width.
  function automatic int unsigned maxv(input int unsigned pix_w);
    return (32'd1 << pix_w) - 32'd1;
  endfunction

  // Keep the band below half scale so salt and pepper can never overlap.
  function automatic int unsigned tol_clamp(input int unsigned tol, input int unsigned pix_w);
    int unsigned lim;
    lim = (32'd1 << (pix_w - 1)) - 32'd1;
    return (tol > lim) ? lim : tol;
  endfunction

  function automatic int unsigned centre_idx(input int unsigned win);
    return win / 2;
  endfunction

endpackage

// File: rtl/noise_detector_stream_if.sv
// Window stream in / flagged window stream out, seen from the upstream (master) or detector (slave) side.
interface noise_detector_stream_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned WIN   = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIN*PIX_W-1:0] in_win;
  logic                 in_last;

  logic                 out_valid;
  logic                 out_ready;
  logic [WIN*PIX_W-1:0] out_win;
  logic [WIN-1:0]       out_salt;
  logic [WIN-1:0]       out_pepper;
  logic                 out_ctr_noisy;
  logic                 out_last;

  modport master (
    output in_valid, in_win, in_last, out_ready,
    input  in_ready, out_valid, out_win, out_salt, out_pepper, out_ctr_noisy, out_last
  );

  modport slave (
    input  in_valid, in_win, in_last, out_ready,
    output in_ready, out_valid, out_win, out_salt, out_pepper, out_ctr_noisy, out_last
  );
endinterface

// File: rtl/noise_detector_stream_classify.sv
// Per-pixel salt/pepper test against a symmetric tolerance band.
module noise_pixel_classify
  import noise_det_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] pix_i,
  input  logic [PIX_W-1:0] tol_i,
  output logic             salt_o,
  output logic             pepper_o
);
  localparam logic [PIX_W-1:0] MAXV = PIX_W'(maxv(PIX_W));

  // tol_i is already clamped below half scale, so MAXV - tol_i cannot underflow.
  assign salt_o   = (pix_i >= (MAXV - tol_i));
  assign pepper_o = (pix_i <= tol_i);
endmodule

// File: rtl/noise_detector_stream.sv
// Two-stage valid/ready pipeline: S1 holds the window with its frame config, S2 holds window plus flags.
module noise_detector_stream
  import noise_det_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF,
  parameter int unsigned WIN   = WIN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_en_i,
  input  logic [PIX_W-1:0]   cfg_tol_i,
  noise_detector_stream_if.slave bus,
  output logic [CNT_W-1:0]   stat_cnt_o,
  output logic               stat_valid_o
);
  localparam int unsigned STAGES = 2;
  localparam int unsigned CTR    = centre_idx(WIN);

  logic [STAGES:1]            vld_q;
  logic                       s2_can_load;
  logic                       in_fire;
  logic                       out_fire;

  logic                       frame_active_q, frame_active_d;
  logic [PIX_W-1:0]           tol_q, tol_d;
  logic                       en_q, en_d;

  logic [WIN-1:0][PIX_W-1:0]  s1_win_q;
  logic                       s1_last_q;
  logic [PIX_W-1:0]           s1_tol_q;
  logic                       s1_en_q;

  logic [WIN-1:0]             salt_raw, pep_raw, salt_f, pep_f;

  logic [WIN-1:0][PIX_W-1:0]  s2_win_q;
  logic                       s2_last_q;
  logic [WIN-1:0]             s2_salt_q, s2_pep_q;
  logic                       s2_ctr_q;

  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]           stat_cnt_q, stat_cnt_d;
  logic                       stat_valid_q, stat_valid_d;

  // Ready depends only on pipeline occupancy and out_ready, never on in_valid.
  assign s2_can_load  = !vld_q[2] || bus.out_ready;
  assign bus.in_ready = !vld_q[1] || s2_can_load;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = vld_q[2] && bus.out_ready;

  // Config is sampled on the first accepted window of a frame and held until its last.
  always_comb begin
    tol_d          = tol_q;
    en_d           = en_q;
    frame_active_d = frame_active_q;
    if (in_fire) begin
      if (!frame_active_q) begin
        tol_d = PIX_W'(tol_clamp(32'(cfg_tol_i), PIX_W));
        en_d  = cfg_en_i;
      end
      frame_active_d = !bus.in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tol_q          <= '0;
      en_q           <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      tol_q          <= tol_d;
      en_q           <= en_d;
      frame_active_q <= frame_active_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      s1_win_q  <= '0;
      s1_last_q <= 1'b0;
      s1_tol_q  <= '0;
      s1_en_q   <= 1'b0;
    end else begin
      if (bus.in_ready) vld_q[1] <= bus.in_valid;
      if (s2_can_load)  vld_q[2] <= vld_q[1];
      if (in_fire) begin
        s1_win_q  <= bus.in_win;
        s1_last_q <= bus.in_last;
        s1_tol_q  <= tol_d;
        s1_en_q   <= en_d;
      end
    end
  end

  for (genvar k = 0; k < WIN; k++) begin : g_pix
    noise_pixel_classify #(.PIX_W(PIX_W)) u_cls (
      .pix_i    (s1_win_q[k]),
      .tol_i    (s1_tol_q),
      .salt_o   (salt_raw[k]),
      .pepper_o (pep_raw[k])
    );
  end

  assign salt_f = s1_en_q ? salt_raw : '0;
  assign pep_f  = s1_en_q ? pep_raw  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_win_q  <= '0;
      s2_last_q <= 1'b0;
      s2_salt_q <= '0;
      s2_pep_q  <= '0;
      s2_ctr_q  <= 1'b0;
    end else if (s2_can_load && vld_q[1]) begin
      s2_win_q  <= s1_win_q;
      s2_last_q <= s1_last_q;
      s2_salt_q <= salt_f;
      s2_pep_q  <= pep_f;
      s2_ctr_q  <= salt_f[CTR] | pep_f[CTR];
    end
  end

  // The last window's own contribution is folded in before the count is published and cleared.
  always_comb begin
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d        = cnt_q;
    stat_cnt_d   = stat_cnt_q;
    stat_valid_d = 1'b0;
    if (out_fire) begin
      if (s2_ctr_q) cnt_d = cnt_inc;
      if (s2_last_q) begin
        stat_cnt_d   = cnt_d;
        stat_valid_d = 1'b1;
        cnt_d        = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      stat_cnt_q   <= '0;
      stat_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stat_cnt_q   <= stat_cnt_d;
      stat_valid_q <= stat_valid_d;
    end
  end

  assign bus.out_valid     = vld_q[2];
  assign bus.out_win       = s2_win_q;
  assign bus.out_salt      = s2_salt_q;
  assign bus.out_pepper    = s2_pep_q;
  assign bus.out_ctr_noisy = s2_ctr_q;
  assign bus.out_last      = s2_last_q;
  assign stat_cnt_o        = stat_cnt_q;
  assign stat_valid_o      = stat_valid_q;

endmodule
